// File: rtl/irq_priority_latch.sv
`default_nettype none
// ============================================================================
// Module      : irq_priority_latch
// Description : Rising-edge request capture with pending/overflow tracking.
//               Offers the highest-priority unmasked pending line (index 0
//               highest) on a valid/ready handshake and clears it on accept.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_priority_latch #(
    parameter int N     = 4,
    parameter int IDX_W = 2     // must equal ceil(log2(N))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask_in,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N-1:0]     pending_o,
    output logic [N-1:0]     ovf_o,
    input  logic             clr_ovf
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_req_d;
    logic [N-1:0]       r_pending;
    logic [N-1:0]       r_ovf;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_out_idx;
    logic               w_valid_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;

    logic [N-1:0]       w_rise;
    logic [N-1:0]       w_cand;
    logic [N-1:0]       w_clr;
    logic [IDX_W-1:0]   w_sel;
    logic               w_any;
    logic               w_hs;

    assign w_rise = req_in & ~r_req_d;
    assign w_cand = r_pending & ~mask_in;
    assign w_any  = |w_cand;
    // Only an offer in flight can be accepted; ready while idle is ignored.
    assign w_hs   = (r_state == OFFER) && out_ready;

    // Lowest set candidate wins: scan from the top so index 0 overwrites last.
    always_comb begin
        w_sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel = i[IDX_W-1:0];
            end
        end
    end

    // One-hot clear of the line being served in this cycle's handshake.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N; i++) begin
            w_clr[i] = w_hs && (r_out_idx == i[IDX_W-1:0]);
        end
    end

    // Edge history, pending set/clear (new edge beats clear) and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_d   <= '0;
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_req_d   <= req_in;
            r_pending <= w_rise | (r_pending & ~w_clr);
            // A set in the same cycle as clr_ovf survives the clear.
            r_ovf     <= (w_rise & r_pending & ~w_clr) | (clr_ovf ? '0 : r_ovf);
        end
    end

    // FSM state and registered offer outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: an offer is latched once and held until accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_out_valid;
        w_idx_nxt   = r_out_idx;
        case (r_state)
            IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_any) begin
                    w_idx_nxt   = w_sel;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign pending_o = r_pending;
    assign ovf_o     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_irq_priority_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_priority_latch
// Description : Directed, scoreboard-checked bench for irq_priority_latch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_priority_latch;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_in;
    logic [N-1:0]     mask_in;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;
    logic [N-1:0]     pending_o;
    logic [N-1:0]     ovf_o;
    logic             clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IDX_W-1:0] exp_q[$];

    irq_priority_latch #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask_in   (mask_in),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending_o (pending_o),
        .ovf_o     (ovf_o),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change and samples are taken here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted offer is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL grant_unexpected: got idx %0d expected no grant at %0t", out_idx, $time);
            end else begin
                check("grant_idx", 32'(out_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_in = '0; mask_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        check("rst_valid",   32'(out_valid), 0);
        check("rst_idx",     32'(out_idx),   0);
        check("rst_pending", 32'(pending_o), 0);
        check("rst_ovf",     32'(ovf_o),     0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // --- single pulse on line 2 ---
        out_ready = 1'b1;
        req_in = 4'b0100; exp_q.push_back(2'd2);
        tick();
        check("t1_pending", 32'(pending_o), 32'b0100);
        check("t1_valid0",  32'(out_valid), 0);
        req_in = 4'b0000;
        tick();
        check("t1_valid1",  32'(out_valid), 1);
        check("t1_idx",     32'(out_idx),   2);
        tick();
        check("t1_cleared", 32'(pending_o), 0);
        check("t1_valid_drop", 32'(out_valid), 0);

        // --- simultaneous edges on lines 1 and 3 ---
        req_in = 4'b1010; exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        tick();
        check("t2_pending", 32'(pending_o), 32'b1010);
        req_in = 4'b0000;
        tick();
        check("t2_idx_first", 32'(out_idx), 1);
        tick();
        check("t2_bubble",   32'(out_valid), 0);
        check("t2_pend_mid", 32'(pending_o), 32'b1000);
        tick();
        check("t2_valid2",   32'(out_valid), 1);
        check("t2_idx_second", 32'(out_idx), 3);
        tick();
        tick();
        check("t2_idle", 32'(out_valid), 0);
        check("t2_q_empty", 32'(exp_q.size()), 0);

        // --- mask holds line 0 back ---
        mask_in = 4'b0001;
        req_in = 4'b0011; exp_q.push_back(2'd1);
        tick();
        check("t3_pending", 32'(pending_o), 32'b0011);
        req_in = 4'b0000;
        tick();
        check("t3_idx_masked", 32'(out_idx), 1);
        tick();
        check("t3_pend_kept", 32'(pending_o), 32'b0001);
        check("t3_no_offer_masked", 32'(out_valid), 0);
        mask_in = 4'b0000; exp_q.push_back(2'd0);
        tick();
        check("t3_valid_unmask", 32'(out_valid), 1);
        check("t3_idx_unmask",   32'(out_idx),   0);
        tick();
        tick();
        check("t3_pend_empty", 32'(pending_o), 0);

        // --- stall on idx 3 while line 0 arrives ---
        out_ready = 1'b0;
        req_in = 4'b1000; exp_q.push_back(2'd3);
        tick();
        req_in = 4'b0000;
        tick();
        for (int c = 0; c < 5; c++) begin
            if (c == 1) req_in = 4'b0001;
            if (c == 2) req_in = 4'b0000;
            tick();
            check("t4_stall_valid", 32'(out_valid), 1);
            check("t4_stall_idx",   32'(out_idx),   3);
        end
        check("t4_pend_stall", 32'(pending_o), 32'b1001);
        out_ready = 1'b1; exp_q.push_back(2'd0);
        tick();
        check("t4_bubble", 32'(out_valid), 0);
        tick();
        check("t4_next_idx", 32'(out_idx), 0);
        tick();
        check("t4_pend_empty", 32'(pending_o), 0);

        // --- overflow on line 2, then clear ---
        out_ready = 1'b0;
        req_in = 4'b0100; exp_q.push_back(2'd2);
        tick();
        req_in = 4'b0000;
        tick();
        req_in = 4'b0100;
        tick();
        check("t5_ovf_set", 32'(ovf_o), 32'b0100);
        req_in = 4'b0000;
        tick();
        clr_ovf = 1'b1; out_ready = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t5_ovf_clr", 32'(ovf_o), 0);
        check("t5_pend_clr", 32'(pending_o), 0);
        tick();
        check("t5_single_grant", 32'(out_valid), 0);

        // --- edge on served line during its handshake ---
        out_ready = 1'b0;
        req_in = 4'b0010; exp_q.push_back(2'd1);
        tick();
        req_in = 4'b0000;
        tick();
        req_in = 4'b0010; out_ready = 1'b1; exp_q.push_back(2'd1);
        tick();
        check("t5_pend_kept", 32'(pending_o), 32'b0010);
        check("t5_no_ovf",    32'(ovf_o),     0);
        req_in = 4'b0000;
        tick();
        check("t5_reoffer", 32'(out_valid), 1);
        check("t5_reoffer_idx", 32'(out_idx), 1);
        tick();
        check("t5_pend_empty", 32'(pending_o), 0);
        check("t5_q_empty", 32'(exp_q.size()), 0);

        // --- asynchronous reset during an offer ---
        out_ready = 1'b0;
        req_in = 4'b1111;
        tick();
        req_in = 4'b0000;
        tick();
        req_in = 4'b1111;
        tick();
        check("t6_pre_valid", 32'(out_valid), 1);
        check("t6_pre_ovf",   32'(ovf_o), 32'b1111);
        #2;
        rst_n = 1'b0;
        req_in = 4'b0001;
        #1;
        check("t6_async_valid",   32'(out_valid), 0);
        check("t6_async_pending", 32'(pending_o), 0);
        check("t6_async_ovf",     32'(ovf_o),     0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; exp_q.push_back(2'd0);
        tick();
        check("t6_rel_pending", 32'(pending_o), 32'b0001);
        check("t6_rel_valid0",  32'(out_valid), 0);
        tick();
        check("t6_rel_valid1", 32'(out_valid), 1);
        check("t6_rel_idx",    32'(out_idx),   0);
        tick();
        check("t6_pend_empty", 32'(pending_o), 0);
        tick();
        check("final_q_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_priority_latch.md
Name: irq_priority_latch

Overview:
- Upstream request-capture stage for the 4-to-2 priority encoder path.
- Detects rising edges on N raw request lines and holds each as a pending bit until it is serviced.
- Selects the highest-priority unmasked pending line (index 0 highest, same order as the encoder) and offers its index downstream on a valid/ready handshake.
- Clears the served bit on handshake and flags lost events.

Parameters:
- N, 4, number of request lines.
- IDX_W, 2, width of the output index; must equal ceil(log2(N)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N  raw request lines, synchronous to clk; a rising edge is an event.
- mask_in  input  N  1 = line blocked from selection; its pending bit is kept.
- out_valid  output  1  out_idx holds a valid offer.
- out_idx  output  IDX_W  index of the offered line.
- out_ready  input  1  downstream accepts the offer.
- pending_o  output  N  current pending vector.
- ovf_o  output  N  sticky per-line overflow flags.
- clr_ovf  input  1  clears all of ovf_o.

Behaviour:
- Reset (async assert, sync use after release):
  - req_d, pending, ovf, out_valid, out_idx and state all reset to 0 / IDLE.
  - A line already high at reset release counts as a rising edge on the first clock.
- Edge detect:
  - rise[i] = req_in[i] & ~req_d[i].
  - req_d <= req_in every cycle.
- Pending update, per bit, priority high to low:
  - rise[i] sets pending[i].
  - Otherwise a handshake on index i clears pending[i].
  - Otherwise pending[i] holds.
  - rise[i] coinciding with a clear of the same bit leaves pending[i]=1: the new event is kept and the old one is served.
- Overflow:
  - rise[i] while pending[i]=1 and the bit is not being cleared this cycle sets ovf[i].
  - clr_ovf clears all ovf bits.
  - A set in the same cycle as clr_ovf wins.
- Selection (combinational):
  - cand = pending & ~mask_in.
  - sel = lowest set index of cand.
  - any = |cand.
- FSM states:
  - IDLE: out_valid=0. If any=1, register out_idx<=sel and out_valid<=1, then go to OFFER. Otherwise stay in IDLE.
  - OFFER: out_valid=1 and out_idx is held stable regardless of mask_in, new edges, or higher-priority arrivals; an offer is never retracted. When out_ready=1, complete the handshake: clear pending[out_idx], drive out_valid<=0, return to IDLE.
- Latency and throughput:
  - A rising edge sampled at clock edge k makes the pending bit visible after edge k.
  - out_valid rises after edge k+1, provided the FSM is in IDLE and the line wins selection.
  - After a handshake there is one mandatory IDLE bubble cycle, so at most one grant per 2 cycles.
- out_ready while out_valid=0 is ignored.
- pending_o and ovf_o reflect the registered state directly.

Test Plan:
- Reset with req_in=0000, then pulse req_in=0100 for one cycle, out_ready=1 → pending_o=0100 after 1 edge; out_valid=1 and out_idx=2 after 2 edges; handshake clears pending_o to 0000 and out_valid returns to 0.
- Simultaneous edges req_in 0000→1010, out_ready=1 → grants in order idx 1 then idx 3, each offer 1 cycle with an IDLE bubble between.
- Mask: pending=0011 with mask_in=0001 → offer idx 1. Unmask after its handshake → offer idx 0 next.
- Stall: offer idx 3 with out_ready=0 for 5 cycles, raise line 0 mid-stall → out_idx stays 3 throughout. After ready, the next offer is idx 0.
- Overflow: edge on line 2, drop and raise it again before service → ovf_o=0100 and still one grant. Pulse clr_ovf → ovf_o=0000. Separately, an edge on the served line during its handshake cycle → pending bit stays 1 and the line is re-offered.
- Reset mid-operation: assert rst_n=0 while in OFFER with pending=1111 → out_valid, pending_o and ovf_o go to 0 immediately without waiting for clk. With req_in held at 0001 across release → idx 0 is offered 2 edges after release.
